mult_div_seq: RTL and testbench
===============================

# mult_div_seq

Multicycle signed multiply/divide sequencer for the multicycle CPU. It owns the HI/LO result registers. It accepts one MULT or DIV request from the control unit, iterates on operand magnitudes for WIDTH cycles, then applies sign correction and writes HI/LO. The control unit holds in a wait state until `done` pulses; the register-file read ports (A/B) supply the operands.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  1  0 = MULT (signed), 1 = DIV (signed)
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  high in RUN and FIN
- done  out  1  one-cycle completion pulse
- div0  out  1  one-cycle pulse, coincident with `done`, on a faulted division
- hi  out  WIDTH  HI register: product upper half / remainder
- lo  out  WIDTH  LO register: product lower half / quotient

## Operation
- States: IDLE, RUN, FIN.
- **IDLE**
  - With `start`=1, latch |a|, |b|, sign(a), sign(b), op; clear accumulator and counter; go to RUN.
  - With `start`=1, `op`=1 and `b`=0: go straight to FIN with the fault flag set.
- **RUN**, WIDTH cycles, counter 0..WIDTH-1:
  - MULT: unsigned shift-add into a 2·WIDTH accumulator.
  - DIV: restoring step. Shift the remainder left with the next dividend bit, trial-subtract |b|, set the quotient bit if the result is non-negative.
  - After counter = WIDTH-1, go to FIN.
- **FIN**, 1 cycle:
  - MULT: negate the 2·WIDTH product if sign(a)^sign(b); hi = upper, lo = lower.
  - DIV: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a). Quotient truncates toward zero; remainder takes the dividend's sign.
  - Assert `done`. Return to IDLE.
- Fault (divide by zero): in FIN assert `done` and `div0`; hi/lo are unchanged.
- Arithmetic: all results are truncated to WIDTH. 0x80000000 / -1 gives lo=0x80000000, hi=0, with no fault.
- hi/lo change only in FIN, and hold between operations.

## Timing
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, div0=0, counter=0. Reset mid-operation aborts the operation, and hi/lo clear to 0.
- `start` sampled at edge 0. `busy`=1 from cycle 1. FIN in cycle WIDTH+1 (33 at default): `done`=1, and hi/lo carry new values from cycle WIDTH+2.
- Faulted DIV: FIN in cycle 1, so `done`/`div0` are high in cycle 1.
- `start` while busy is ignored; no queueing.
- `start` in the same cycle as FIN is ignored; it is accepted only from the following IDLE cycle.
- Operands are needed only in the `start` cycle; later changes to a/b have no effect.
- `done` and `div0` are never high for more than one cycle.

## Configuration
- MD_DIVIDER_EN defined: DIV is implemented as described above.
- MD_DIVIDER_EN undefined:
  - Restoring-divide logic is removed.
  - op=1 goes IDLE→FIN, with `done` and `div0` high in cycle 1 and hi/lo unchanged.
  - MULT is unaffected.

## Structure
- Shared package `cpu_pkg`:
  - funct constants FUNCT_MULT=6'h18, FUNCT_DIV=6'h1a
  - op encoding MD_OP_MULT=0, MD_OP_DIV=1
  - state encoding MD_IDLE/MD_RUN/MD_FIN
- Sub-module `div_step`: combinational restoring step (remainder, dividend bit, divisor → next remainder, quotient bit). Instantiated only under MD_DIVIDER_EN.
- The counter, magnitude/sign latches and FIN negation live in `mult_div_seq`.

## Test plan
- MULT a=7, b=-3 (0xFFFFFFFD) → `done` in cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; div0=0.
- MULT a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0x00000000.
- DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); `done` in cycle 33.
- DIV a=5, b=0 after a prior result hi=0x11, lo=0x22 → `done` and `div0` in cycle 1; hi=0x11, lo=0x22 unchanged.
- MULT 3×4 started, second `start` (DIV 9/3) pulsed in cycle 10 → ignored; hi=0, lo=12; no second `done`.
- MULT started, reset asserted in cycle 10 → the next cycle shows busy=0, hi=lo=0, and no `done` appears; a new DIV 100/7 then gives lo=14, hi=2.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: funct codes, mul/div op encoding, sequencer states
package cpu_pkg;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1a;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIN  = 2'd2
    } md_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on unsigned magnitudes
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor on entry, so both the kept and the subtracted value fit WIDTH bits
    always_comb begin
        shifted  = {rem, dividend_bit};
        trial    = shifted - {1'b0, divisor};
        q_bit    = (shifted >= {1'b0, divisor});
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - multicycle signed MULT/DIV sequencer owning HI/LO; divider enabled by MD_DIVIDER_EN
module mult_div_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    md_state_t          state;
    md_state_t          state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               sign_a;
    logic               sign_b;
    logic               op_q;
    logic               fault;
    logic               fault_req;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // operand magnitudes and whether a new request goes straight to the fault path
    always_comb begin
        mag_a = a[WIDTH-1] ? -a : a;
        mag_b = b[WIDTH-1] ? -b : b;
`ifdef MD_DIVIDER_EN
        fault_req = (op == MD_OP_DIV) && (b == '0);
`else
        fault_req = (op == MD_OP_DIV);
`endif
    end

    // MULT: acc = {partial product, remaining multiplier bits}, shift right each step
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    end

`ifdef MD_DIVIDER_EN
    logic [WIDTH-1:0] div_rem;
    logic             div_q;

    // DIV: acc = {remainder, dividend bits shifting out / quotient bits shifting in}
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (acc[2*WIDTH-1:WIDTH]),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (opnd),
        .rem_next     (div_rem),
        .q_bit        (div_q)
    );

    // select the iteration for the latched operation
    always_comb begin
        step_next = {mul_sum, acc[WIDTH-1:1]};
        if (op_q == MD_OP_DIV) begin
            step_next = {div_rem, acc[WIDTH-2:0], div_q};
        end
    end
`else
    // multiply is the only iteration without the divider
    always_comb begin
        step_next = {mul_sum, acc[WIDTH-1:1]};
    end
`endif

    // sign correction applied in FIN: quotient follows sign xor, remainder follows dividend
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div0       = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_next = fault_req ? MD_FIN : MD_RUN;
                end
            end
            MD_RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    state_next = MD_FIN;
                end
            end
            MD_FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                div0       = fault;
                state_next = MD_IDLE;
            end
            default: state_next = MD_IDLE;
        endcase
    end

    // datapath: latch request, iterate, commit HI/LO once in FIN
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            op_q   <= MD_OP_MULT;
            fault  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
                        count  <= '0;
                        fault  <= fault_req;
                        if (op == MD_OP_DIV) begin
                            opnd <= mag_b;
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            opnd <= mag_a;
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                        end
                    end
                end
                MD_RUN: begin
                    acc   <= step_next;
                    count <= count + CW'(1);
                end
                MD_FIN: begin
                    if (!fault) begin
                        if (op_q == MD_OP_DIV) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// tb/tb_mult_div_seq.sv - self-checking bench for mult_div_seq against an arithmetic reference model
module tb_mult_div_seq;

`ifdef MD_DIVIDER_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic op_i, input logic [31:0] b_i);
        return op_i && (!DIV_EN || b_i == 32'd0);
    endfunction

    // signed results computed with 64-bit integer arithmetic, then truncated to 32 bits
    function automatic logic [63:0] model(input logic op_i, input logic [31:0] a_i,
                                          input logic [31:0] b_i, input logic [63:0] prev);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        if (!op_i) begin
            p = sa * sb;
            return p[63:0];
        end
        if (is_fault(op_i, b_i)) return prev;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // one request from IDLE; optional extra start pulse at cycle pulse_cycle (DIV 9/3)
    task automatic run_op(input string tag, input logic op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input int pulse_cycle);
        logic [63:0] exp;
        bit          flt;
        int          cyc;
        int          done_cyc;
        int          n_done;
        int          stray;
        logic        div0_at_done;
        flt = is_fault(op_i, b_i);
        exp = model(op_i, a_i, b_i, {m_hi, m_lo});
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        @(posedge clk);
        cyc = 0; done_cyc = -1; n_done = 0; stray = 0; div0_at_done = 1'b0;
        while (cyc < 60 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; a = $urandom; b = $urandom;
            if (cyc == 1) check({tag, "_busy_c1"}, 64'(busy), 64'd1);
            if (done) begin
                done_cyc     = cyc;
                div0_at_done = div0;
                check({tag, "_hold_at_done"}, {hi, lo}, {m_hi, m_lo});
            end else if (div0) begin
                stray++;
            end
            if (cyc == pulse_cycle) begin
                start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
            end
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(flt ? 1 : 33));
        check({tag, "_div0"}, 64'(div0_at_done), 64'(flt));
        @(negedge clk);
        start = 1'b0;
        check({tag, "_result"}, {hi, lo}, exp);
        check({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
            if (div0) stray++;
        end
        check({tag, "_quiet"}, 64'(n_done + stray), 64'd0);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rop;
        int          sel;
        int          n_done;

        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_flags", {61'd0, busy, done, div0}, 64'd0);

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
        check("mul_7_m3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 33);
        check("mul_min_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        if (DIV_EN) check("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_setup", 1'b1, 32'h451, 32'h20, -1);
        run_op("div_by_zero", 1'b1, 32'd5, 32'd0, 1);
        run_op("mul_3_4_ignore", 1'b0, 32'd3, 32'd4, 10);
        check("mul_3_4_const", {hi, lo}, 64'd12);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);

        // reset in the middle of a MULT
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || div0 || busy) n_done++;
        end
        check("midreset_no_done", 64'(n_done), 64'd0);
        m_hi = '0; m_lo = '0;
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, -1);

        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 9);
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 32'd0;
            if (sel == 1) rb = 32'($signed($urandom_range(0, 16)) - 8);
            if (sel == 2) begin rop = 1'b1; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 3) ra = 32'($signed($urandom_range(0, 200)) - 100);
            run_op("rand", rop, ra, rb, (sel == 4) ? 33 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
